// File: rtl/tdm_demux_1to4.sv
// tdm_demux_1to4: steers a 4-slot TDM word stream into per-channel registers with sync lock tracking
module tdm_demux_1to4 #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic             in_sync,
  input  logic [WIDTH-1:0] in_data,
  output logic [WIDTH-1:0] ch0_data,
  output logic [WIDTH-1:0] ch1_data,
  output logic [WIDTH-1:0] ch2_data,
  output logic [WIDTH-1:0] ch3_data,
  output logic [3:0]       ch_valid,
  output logic             frame_valid,
  output logic             sync_err,
  output logic             locked
);
  typedef enum logic {HUNT, LOCKED} state_t;
  state_t state, state_nx;
  logic [1:0] slot, slot_nx, wr_ch;
  logic wr, fv_nx, err_nx;
  logic [WIDTH-1:0] ch [4];
  assign ch0_data = ch[0];
  assign ch1_data = ch[1];
  assign ch2_data = ch[2];
  assign ch3_data = ch[3];
  // next state, slot and strobe decode for the accepted word
  always_comb begin
    state_nx = state;
    slot_nx  = slot;
    wr       = 1'b0;
    wr_ch    = 2'd0;
    fv_nx    = 1'b0;
    err_nx   = 1'b0;
    if (in_valid) begin
      if (in_sync) begin
        wr       = 1'b1;
        slot_nx  = 2'd1;
        state_nx = LOCKED;
        err_nx   = state == LOCKED && slot != 2'd0;
      end else if (state == LOCKED) begin
        if (slot == 2'd0) begin
          err_nx   = 1'b1;
          state_nx = HUNT;
        end else begin
          wr      = 1'b1;
          wr_ch   = slot;
          slot_nx = slot + 2'd1;
          fv_nx   = slot == 2'd3;
        end
      end
    end
  end
  // state, channel registers and registered strobes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= HUNT;
      slot        <= 2'd0;
      ch          <= '{default: '0};
      ch_valid    <= 4'd0;
      frame_valid <= 1'b0;
      sync_err    <= 1'b0;
      locked      <= 1'b0;
    end else begin
      state       <= state_nx;
      slot        <= slot_nx;
      ch_valid    <= wr ? 4'd1 << wr_ch : 4'd0;
      frame_valid <= fv_nx;
      sync_err    <= err_nx;
      locked      <= state_nx == LOCKED;
      if (wr) ch[wr_ch] <= in_data;
    end
  end
endmodule

// File: tb/tb_tdm_demux_1to4.sv
// tb_tdm_demux_1to4: directed checks of lock, hunt, gaps, resync, loss of lock and async reset
module tb_tdm_demux_1to4;
  logic clk = 0, rst_n = 0, in_valid = 0, in_sync = 0;
  logic [7:0] in_data = 0;
  logic [7:0] ch0_data, ch1_data, ch2_data, ch3_data;
  logic [3:0] ch_valid;
  logic frame_valid, sync_err, locked;
  int n_chk = 0, n_err = 0;

  tdm_demux_1to4 #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_sync(in_sync), .in_data(in_data),
    .ch0_data(ch0_data), .ch1_data(ch1_data), .ch2_data(ch2_data), .ch3_data(ch3_data),
    .ch_valid(ch_valid), .frame_valid(frame_valid), .sync_err(sync_err), .locked(locked)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic st(input string tag, input logic [6:0] exp);
    chk(tag, {25'd0, ch_valid, frame_valid, sync_err, locked}, {25'd0, exp});
  endtask

  task automatic dat(input string tag, input logic [31:0] exp);
    chk(tag, {ch3_data, ch2_data, ch1_data, ch0_data}, exp);
  endtask

  task automatic send(input logic v, input logic s, input logic [7:0] d);
    in_valid = v;
    in_sync  = s;
    in_data  = d;
    @(posedge clk);
    #1;
    in_valid = 0;
    in_sync  = 0;
  endtask

  initial begin
    @(posedge clk);
    #1;
    st("rst_st", 7'b0000_000);
    dat("rst_dat", 32'h0);
    rst_n = 1;
    send(1, 1, 8'hA0); st("lk0", 7'b0001_001);
    send(1, 0, 8'hA1); st("lk1", 7'b0010_001);
    send(1, 0, 8'hA2); st("lk2", 7'b0100_001);
    send(1, 0, 8'hA3); st("lk3", 7'b1000_101);
    dat("lk_dat", 32'hA3A2A1A0);
    send(0, 0, 8'h00); st("idle", 7'b0000_001);
    send(1, 0, 8'h77); st("miss", 7'b0000_010);
    dat("miss_dat", 32'hA3A2A1A0);
    send(1, 0, 8'h11); st("hunt1", 7'b0000_000);
    send(1, 0, 8'h22); st("hunt2", 7'b0000_000);
    dat("hunt_dat", 32'hA3A2A1A0);
    send(1, 1, 8'h33); st("relock", 7'b0001_001);
    send(1, 0, 8'h34); st("f1", 7'b0010_001);
    send(1, 0, 8'h35); st("f2", 7'b0100_001);
    send(1, 0, 8'h36); st("f3", 7'b1000_101);
    dat("f_dat", 32'h36353433);
    for (int i = 0; i < 4; i++) begin
      send(1, i == 0, 8'h10 + 8'(i));
      st("gap_w", {4'd1 << i, i == 3, 1'b0, 1'b1});
      if (i < 3)
        for (int g = 0; g < 2; g++) begin
          send(0, 1, 8'hEE);
          st("gap_idle", 7'b0000_001);
        end
    end
    dat("gap_dat", 32'h13121110);
    send(1, 1, 8'h50); st("es0", 7'b0001_001);
    send(1, 0, 8'h51); st("es1", 7'b0010_001);
    dat("es_stale", 32'h13125150);
    send(1, 1, 8'h60); st("es_err", 7'b0001_011);
    send(1, 0, 8'h61); st("es61", 7'b0010_001);
    send(1, 0, 8'h62); st("es62", 7'b0100_001);
    send(1, 0, 8'h63); st("es63", 7'b1000_101);
    dat("es_dat", 32'h63626160);
    send(1, 1, 8'h80);
    send(1, 0, 8'h81); st("mr_pre", 7'b0010_001);
    rst_n = 0;
    #1;
    st("mr_st", 7'b0000_000);
    dat("mr_dat", 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1;
    send(1, 0, 8'h99); st("mr_drop", 7'b0000_000);
    dat("mr_drop_dat", 32'h0);
    send(1, 1, 8'h9A); st("mr_lock", 7'b0001_001);
    dat("mr_lock_dat", 32'h0000009A);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/tdm_demux_1to4.md
# tdm_demux_1to4

Time-division demultiplexer: receives one shared word stream carrying four interleaved channels and steers each word into its own channel register. It is the receive end of the 4-to-1 channel multiplexer path. A sync flag marks slot 0 of every frame, and the block tracks frame alignment with a two-state lock machine. Per-channel strobes, a frame-complete strobe and a sync-error strobe go to downstream logic.

## Interface
- WIDTH, 8, data word width in bits
- clk  input  1  rising-edge clock; the only clock in the block
- rst_n  input  1  asynchronous, active-low reset
- in_valid  input  1  in_data/in_sync are valid this cycle; a word is accepted on every clk edge where in_valid=1
- in_sync  input  1  qualifies the current word as slot 0 (channel 0); ignored when in_valid=0
- in_data  input  WIDTH  stream word
- ch0_data, ch1_data, ch2_data, ch3_data  output  WIDTH each  registered channel words
- ch_valid  output  4  one-cycle strobe; bit n is high in the cycle chn_data updates
- frame_valid  output  1  one-cycle strobe; all four chn_data hold one complete, aligned frame
- sync_err  output  1  one-cycle strobe on an alignment violation
- locked  output  1  high while the state is LOCKED

## Operation
- States: HUNT and LOCKED. The block also keeps a 2-bit slot counter, slot, which is the index of the next expected channel.
- Reset: rst_n=0 asynchronously clears all of the following:
  - state goes to HUNT and slot to 0
  - ch0..ch3_data, ch_valid, frame_valid, sync_err and locked go to 0
- HUNT:
  - A word with in_valid=1 and in_sync=0 is dropped with no strobes.
  - A word with in_valid=1 and in_sync=1 is written to ch0_data. ch_valid[0] pulses, slot becomes 1 and the state becomes LOCKED.
- LOCKED, accepted word with slot=0 and in_sync=1: normal frame start. Write ch0_data, pulse ch_valid[0], slot becomes 1.
- LOCKED, accepted word with slot=1..3 and in_sync=0:
  - Write ch[slot]_data, pulse ch_valid[slot], and slot becomes (slot+1) mod 4.
  - At slot=3, also pulse frame_valid and wrap slot to 0.
- LOCKED, accepted word with slot=1..3 and in_sync=1 (early sync): resync.
  - Pulse sync_err and discard the partial frame; no frame_valid is generated for it.
  - Write the word to ch0_data, pulse ch_valid[0], slot becomes 1, and the state stays LOCKED.
- LOCKED, accepted word with slot=0 and in_sync=0 (missing sync): loss of lock.
  - Pulse sync_err and drop the word; no ch_valid pulse.
  - State becomes HUNT and slot becomes 0.
- in_valid=0: state, slot and all chn_data hold, and every strobe is 0. Gaps may occur anywhere inside a frame.
- Channel registers are never cleared except by reset. A discarded partial frame leaves stale values in the higher channels, and only frame_valid certifies alignment.
- At most one ch_valid bit is high in any cycle. frame_valid is high only together with ch_valid[3]. sync_err and frame_valid are never high together.

## Timing
- Latency: a word accepted at edge k appears on chn_data, ch_valid[n] and (if applicable) frame_valid immediately after edge k, i.e. one cycle of registration.
- All outputs are registered. There are no combinational paths from the inputs to the outputs.
- Full rate: one word per cycle is sustained indefinitely, so a frame takes 4 cycles with no bubbles.
- locked goes high after the edge that accepts the first sync word. It goes low after the edge that detects a missing sync.
- Reset asserted mid-frame takes effect immediately. After release, the block is in HUNT and the first word without sync is dropped.
- Reset release is synchronous to clk. The first possible acceptance is the first rising edge with rst_n=1.

## Test plan
- Reset then lock:
  - Stimulus: after reset, stream (sync)0xA0,0xA1,0xA2,0xA3 back-to-back.
  - Response: ch_valid goes 0001,0010,0100,1000; frame_valid pulses on the 4th cycle with ch0..3=A0,A1,A2,A3; locked=1 from the 1st output cycle.
- Hunt drop:
  - Stimulus: 0x11,0x22 without sync, then (sync)0x33.
  - Response: no strobes for the first two words; ch0_data=0x33; locked rises only after the 3rd word.
- Gapped frame:
  - Stimulus: frame 0x10..0x13 with in_valid low for 2 cycles between each word.
  - Response: same data and frame_valid as the back-to-back case; outputs hold during gaps; all strobes are 0 during gaps.
- Early sync:
  - Stimulus: (sync)0x50,0x51, then (sync)0x60,0x61,0x62,0x63.
  - Response: sync_err pulses when 0x60 is accepted; no frame_valid for 0x50/0x51; frame_valid pulses with 0x60..0x63.
- Missing sync:
  - Stimulus: a complete frame, then 0x77 without sync.
  - Response: sync_err pulses, ch0_data keeps the prior value, locked=0; the next sync word relocks.
- Mid-frame reset:
  - Stimulus: assert rst_n=0 after 2 words of a frame.
  - Response: all outputs are 0 immediately (asynchronously); after release, 0x99 without sync is dropped.
